// File: rtl/scan_pkg.sv
// Shared types for the bounce/wrap position scanner: state encoding and direction constants.
package scan_pkg;

  typedef enum logic [1:0] {
    MOVE_UP = 2'd0,
    MOVE_DN = 2'd1,
    HOLD_HI = 2'd2,
    HOLD_LO = 2'd3
  } scan_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter timing the dwell at a bound; done flags the final held step.
module scan_dwell_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The step that sees a count of one is the last held step.
  assign done = (count == W'(1));

endmodule

// File: rtl/bounce_scan_ctrl.sv
// Position scanner walking pos between runtime bounds lo..hi in bounce or wrap mode.
// Optional dwell at each bound is compiled in with `define BOUNCE_SCAN_DWELL_EN.
module bounce_scan_ctrl
  import scan_pkg::*;
#(
  parameter int POS_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               step,
  input  logic               clr,
  input  logic               wrap,
  input  logic [POS_W-1:0]   lo,
  input  logic [POS_W-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  output logic [POS_W-1:0]   pos,
  output logic               dir,
  output logic               at_edge,
  output logic               holding
);

  scan_state_e      state, state_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             dir_nxt;
  logic             edge_nxt;
  logic             holding_nxt;
  logic             cnt_load, cnt_dec, cnt_clr, cnt_done;
  logic             dwell_go;

`ifdef BOUNCE_SCAN_DWELL_EN
  scan_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (dwell),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );
  assign dwell_go    = (dwell != '0);
  assign holding_nxt = (state_nxt == HOLD_HI) || (state_nxt == HOLD_LO);
`else
  logic unused_dwell;
  assign unused_dwell = ^{dwell, cnt_load, cnt_dec, cnt_clr};
  assign cnt_done     = 1'b0;
  assign dwell_go     = 1'b0;
  assign holding_nxt  = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= MOVE_UP;
      pos     <= '0;
      dir     <= DIR_UP;
      at_edge <= 1'b0;
      holding <= 1'b0;
    end else begin
      state   <= state_nxt;
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      at_edge <= edge_nxt;
      holding <= holding_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    dir_nxt   = dir;
    edge_nxt  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;

    if (clr) begin
      pos_nxt   = lo;
      dir_nxt   = DIR_UP;
      state_nxt = MOVE_UP;
      cnt_clr   = 1'b1;
    end else if (lo >= hi) begin
      // Degenerate window: park on lo every cycle, motion state frozen.
      pos_nxt = lo;
    end else if (step) begin
      if (pos < lo) begin
        pos_nxt   = lo;
        dir_nxt   = DIR_UP;
        state_nxt = MOVE_UP;
      end else if (pos > hi) begin
        pos_nxt   = hi;
        dir_nxt   = DIR_DN;
        state_nxt = MOVE_DN;
      end else begin
        case (state)
          MOVE_UP: begin
            if (pos < hi) begin
              pos_nxt = pos + 1'b1;
              if (pos_nxt == hi) begin
                edge_nxt = 1'b1;
                if (!wrap) begin
                  if (dwell_go) begin
                    state_nxt = HOLD_HI;
                    cnt_load  = 1'b1;
                  end else begin
                    state_nxt = MOVE_DN;
                    dir_nxt   = DIR_DN;
                  end
                end
              end
            end else if (wrap) begin
              pos_nxt  = lo;
              edge_nxt = 1'b1;
            end else begin
              // Sitting on hi while moving up only happens after a mode or bound change.
              pos_nxt   = hi - 1'b1;
              dir_nxt   = DIR_DN;
              state_nxt = MOVE_DN;
              edge_nxt  = (pos_nxt == lo);
            end
          end

          MOVE_DN: begin
            if (wrap) begin
              dir_nxt   = DIR_UP;
              state_nxt = MOVE_UP;
            end else if (pos > lo) begin
              pos_nxt = pos - 1'b1;
              if (pos_nxt == lo) begin
                edge_nxt = 1'b1;
                if (dwell_go) begin
                  state_nxt = HOLD_LO;
                  cnt_load  = 1'b1;
                end else begin
                  state_nxt = MOVE_UP;
                  dir_nxt   = DIR_UP;
                end
              end
            end else begin
              pos_nxt   = lo + 1'b1;
              dir_nxt   = DIR_UP;
              state_nxt = MOVE_UP;
              edge_nxt  = (pos_nxt == hi);
            end
          end

          HOLD_HI: begin
            cnt_dec = 1'b1;
            if (cnt_done) begin
              state_nxt = MOVE_DN;
              dir_nxt   = DIR_DN;
            end
          end

          HOLD_LO: begin
            cnt_dec = 1'b1;
            if (cnt_done) begin
              state_nxt = MOVE_UP;
              dir_nxt   = DIR_UP;
            end
          end

          default: begin
            state_nxt = MOVE_UP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bounce_scan_ctrl.sv
// Scoreboard bench for bounce_scan_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_bounce_scan_ctrl;

  localparam int POS_W   = 3;
  localparam int DWELL_W = 4;

`ifdef BOUNCE_SCAN_DWELL_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  logic               clk    = 1'b0;
  logic               arst_n = 1'b0;
  logic               step   = 1'b0;
  logic               clr    = 1'b0;
  logic               wrap   = 1'b0;
  logic [POS_W-1:0]   lo     = '0;
  logic [POS_W-1:0]   hi     = 3'd7;
  logic [DWELL_W-1:0] dwell  = '0;
  logic [POS_W-1:0]   pos;
  logic               dir;
  logic               at_edge;
  logic               holding;

  bounce_scan_ctrl #(.POS_W(POS_W), .DWELL_W(DWELL_W)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .step    (step),
    .clr     (clr),
    .wrap    (wrap),
    .lo      (lo),
    .hi      (hi),
    .dwell   (dwell),
    .pos     (pos),
    .dir     (dir),
    .at_edge (at_edge),
    .holding (holding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             at_edge;
    logic             holding;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Configuration the next stimulus cycle will present.
  int cfg_lo = 0, cfg_hi = 7, cfg_dwell = 0;
  bit cfg_wrap = 1'b0;

  // Reference model: position as an integer, travel direction, and steps left to hold.
  int m_pos  = 0;
  bit m_up   = 1'b1;
  int m_hold = 0;
  bit m_edge = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic modelReset();
    m_pos  = 0;
    m_up   = 1'b1;
    m_hold = 0;
    m_edge = 1'b0;
  endtask

  // Advance the model one clock with the inputs currently driven and queue the expectation.
  task automatic modelStep();
    exp_t e;
    m_edge = 1'b0;
    if (clr) begin
      m_pos  = cfg_lo;
      m_up   = 1'b1;
      m_hold = 0;
    end else if (cfg_lo >= cfg_hi) begin
      m_pos = cfg_lo;
    end else if (step) begin
      if (m_pos < cfg_lo) begin
        m_pos = cfg_lo; m_up = 1'b1; m_hold = 0;
      end else if (m_pos > cfg_hi) begin
        m_pos = cfg_hi; m_up = 1'b0; m_hold = 0;
      end else if (m_hold > 0) begin
        if (m_hold == 1) begin
          m_hold = 0;
          m_up   = !m_up;
        end else begin
          m_hold--;
        end
      end else if (m_up) begin
        if (m_pos < cfg_hi) begin
          m_pos++;
          if (m_pos == cfg_hi) begin
            m_edge = 1'b1;
            if (!cfg_wrap) begin
              if (DWELL_ON && cfg_dwell != 0) m_hold = cfg_dwell;
              else m_up = 1'b0;
            end
          end
        end else if (cfg_wrap) begin
          m_pos  = cfg_lo;
          m_edge = 1'b1;
        end else begin
          m_pos  = cfg_hi - 1;
          m_up   = 1'b0;
          m_edge = (m_pos == cfg_lo);
        end
      end else begin
        if (cfg_wrap) begin
          m_up = 1'b1;
        end else if (m_pos > cfg_lo) begin
          m_pos--;
          if (m_pos == cfg_lo) begin
            m_edge = 1'b1;
            if (DWELL_ON && cfg_dwell != 0) m_hold = cfg_dwell;
            else m_up = 1'b1;
          end
        end else begin
          m_pos  = cfg_lo + 1;
          m_up   = 1'b1;
          m_edge = (m_pos == cfg_hi);
        end
      end
    end
    e.pos     = m_pos[POS_W-1:0];
    e.dir     = m_up;
    e.at_edge = m_edge;
    e.holding = (m_hold > 0);
    exp_q.push_back(e);
  endtask

  task automatic driveInputs(input bit s, input bit c);
    step  = s;
    clr   = c;
    wrap  = cfg_wrap;
    lo    = cfg_lo[POS_W-1:0];
    hi    = cfg_hi[POS_W-1:0];
    dwell = cfg_dwell[DWELL_W-1:0];
  endtask

  task automatic applyStimulus(input bit s, input bit c);
    @(negedge clk);
    driveInputs(s, c);
    modelStep();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pos"}, int'(pos), 0);
    checkOutput({tag, "_dir"}, int'(dir), 1);
    checkOutput({tag, "_at_edge"}, int'(at_edge), 0);
    checkOutput({tag, "_holding"}, int'(holding), 0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    arst_n = 1'b1;
    driveInputs(1'b0, 1'b0);
    modelStep();
  endtask

  // Async reset asserted between edges, after the monitor has consumed the pending expectation.
  task automatic resetMid();
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    modelReset();
    @(negedge clk);
    releaseReset();
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("pos", int'(pos), int'(mon_e.pos));
        checkOutput("dir", int'(dir), int'(mon_e.dir));
        checkOutput("at_edge", int'(at_edge), int'(mon_e.at_edge));
        checkOutput("holding", int'(holding), int'(mon_e.holding));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin : driver
    #12;
    checkResetValues("reset");
    modelReset();
    releaseReset();

    // Full bounce sweep 0..7
    cfg_lo = 0; cfg_hi = 7; cfg_wrap = 1'b0; cfg_dwell = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);

    // Restart, climb to 7, come down to 5, then clr together with step
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);

    // Wrap mode in 2..5 starting from reset position 0 (out-of-range correction first)
    cfg_lo = 2; cfg_hi = 5; cfg_wrap = 1'b1;
    resetMid();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);

    // Bounce 0..3 with a dwell of 3 steps at each bound
    cfg_lo = 0; cfg_hi = 3; cfg_wrap = 1'b0; cfg_dwell = 3;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);

    // Reset while holding (or mid-sweep without dwell), then resume
    resetMid();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);

    // Degenerate window 6..6
    cfg_lo = 6; cfg_hi = 6;
    for (int i = 0; i < 6; i++) applyStimulus(i % 3 != 0, 1'b0);

    // Randomized traffic with runtime bound, mode and dwell changes
    cfg_lo = 0; cfg_hi = 7; cfg_dwell = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 5) == 0) begin
          cfg_lo = $urandom_range(0, 7);
          cfg_hi = $urandom_range(0, 7);
        end else begin
          cfg_lo = $urandom_range(0, 3);
          cfg_hi = $urandom_range(cfg_lo + 1, 7);
        end
      end
      if ($urandom_range(0, 39) == 0) cfg_wrap = !cfg_wrap;
      if ($urandom_range(0, 19) == 0) cfg_dwell = $urandom_range(0, 3);
      if (i == 300) resetMid();
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
